regfile_write_arbiter: RTL and testbench

//  Shares the single write port of the 32x16 register file among N requesters.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/rr_picker.sv | 40 ++++
 rtl/regfile_write_arbiter.sv | 160 ++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, arbiter state encoding and small helpers for the register-file write arbiter.
package regfile_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 16;
  localparam int RF_DEPTH  = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic int gid_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping modulo N.
// Zero latency; no state, so no backpressure of its own.
module rr_picker #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    sum   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_i} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end
      cand = sum[IW-1:0];
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register-file write port with bounded burst lock; one registered write stage (latency 1).
// Losers and non-owners during a lock simply see req_ready=0; REGFILE_ARB_R0_ZERO_EN suppresses writes to register 0.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int LOCK_MAX = 4,
  parameter int GID_W    = (N_REQ <= 2) ? 1 : $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_lock,
  input  logic [N_REQ*RF_ADDR_W-1:0] req_addr,
  input  logic [N_REQ*RF_DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic [RF_ADDR_W-1:0]       rf_write_addr,
  output logic [RF_DATA_W-1:0]       rf_write_data,
  output logic                       rf_write_en,
  output logic [GID_W-1:0]           grant_id,
  output logic                       locked
);

  localparam logic [3:0] LOCK_MAX_C = 4'(LOCK_MAX);

  arb_state_e             state_q, state_d;
  logic [GID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [GID_W-1:0]       owner_q, owner_d;
  logic [3:0]             beat_cnt_q, beat_cnt_d;
  logic                   wr_en_q, wr_en_d;
  logic [RF_ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [RF_DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [GID_W-1:0]       grant_id_q, grant_id_d;

  logic [N_REQ-1:0]       pick_gnt;
  logic [GID_W-1:0]       pick_idx;
  logic                   pick_any;
  logic [GID_W-1:0]       sel_idx;
  logic [RF_ADDR_W-1:0]   sel_addr;
  logic [RF_DATA_W-1:0]   sel_data;
  logic                   sel_lock;
  logic                   xfer;

  function automatic logic [GID_W-1:0] next_ptr(input logic [GID_W-1:0] x);
    return (x == GID_W'(N_REQ-1)) ? '0 : x + GID_W'(1);
  endfunction

  rr_picker #(
    .N  (N_REQ),
    .IW (GID_W)
  ) u_picker (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Ready is suppressed while rst_n is low so nothing is accepted in the reset cycle.
  always_comb begin
    req_ready = '0;
    if (rst_n) begin
      if (state_q == IDLE) begin
        req_ready = pick_any ? pick_gnt : '0;
      end else begin
        for (int i = 0; i < N_REQ; i++) begin
          if (owner_q == GID_W'(i)) begin
            req_ready[i] = req_valid[i];
          end
        end
      end
    end
  end

  assign xfer    = |(req_valid & req_ready);
  assign sel_idx = (state_q == IDLE) ? pick_idx : owner_q;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_lock = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_idx == GID_W'(i)) begin
        sel_addr = req_addr[i*RF_ADDR_W +: RF_ADDR_W];
        sel_data = req_data[i*RF_DATA_W +: RF_DATA_W];
        sel_lock = req_lock[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    grant_id_d = grant_id_q;
    if (xfer) begin
      grant_id_d = sel_idx;
      if (state_q == IDLE) begin
        rr_ptr_d = next_ptr(sel_idx);
        if (sel_lock && (LOCK_MAX > 1)) begin
          state_d    = LOCKED;
          owner_d    = sel_idx;
          beat_cnt_d = 4'd1;
        end
      end else begin
        beat_cnt_d = beat_cnt_q + 4'd1;
        // Owner idle cycles never reach here, so they neither count nor release.
        if (!sel_lock || (beat_cnt_q + 4'd1 == LOCK_MAX_C)) begin
          state_d    = IDLE;
          rr_ptr_d   = next_ptr(owner_q);
          beat_cnt_d = 4'd0;
        end
      end
    end
  end

  always_comb begin
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef REGFILE_ARB_R0_ZERO_EN
    wr_en_d   = xfer && (sel_addr != '0);
`else
    wr_en_d   = xfer;
`endif
    if (xfer) begin
      wr_addr_d = sel_addr;
      wr_data_d = sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign rf_write_en   = wr_en_q;
  assign rf_write_addr = wr_addr_q;
  assign rf_write_data = wr_data_q;
  assign grant_id      = grant_id_q;
  assign locked        = (state_q == LOCKED);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected writes queued at grant time, popped when rf_write_en fires.
module tb_regfile_write_arbiter;

  localparam int N  = 3;
  localparam int GW = 2;
`ifdef REGFILE_ARB_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]    addr;
    logic [15:0]   data;
    logic [GW-1:0] gid;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_lock;
  logic [N*5-1:0]  req_addr;
  logic [N*16-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic [4:0]    rf_write_addr;
  logic [15:0]   rf_write_data;
  logic          rf_write_en;
  logic [GW-1:0] grant_id;
  logic          locked;

  logic [4:0]  a [N];
  logic [15:0] d [N];
  exp_t        sb [$];
  int          total;
  int          bad;

  assign req_addr = {a[2], a[1], a[0]};
  assign req_data = {d[2], d[1], d[0]};

  regfile_write_arbiter #(
    .N_REQ    (3),
    .LOCK_MAX (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_lock      (req_lock),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data),
    .rf_write_en   (rf_write_en),
    .grant_id      (grant_id),
    .locked        (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after inputs are driven at a negedge; checks ready/locked,
  // queues the expected write, then checks the write stage one cycle later.
  task automatic step(input logic [N-1:0] exp_rdy, input logic exp_lock, input string tag);
    exp_t e;
    logic exp_wr;
    exp_wr = 1'b0;
    #1;
    chk({tag, "_ready"}, 64'(req_ready), 64'(exp_rdy));
    chk({tag, "_locked"}, 64'(locked), 64'(exp_lock));
    for (int i = 0; i < N; i++) begin
      if (exp_rdy[i]) begin
        exp_wr = !(R0Z && (a[i] == 5'd0));
        if (exp_wr) begin
          e.addr = a[i];
          e.data = d[i];
          e.gid  = GW'(i);
          sb.push_back(e);
        end
      end
    end
    @(negedge clk);
    chk({tag, "_wen"}, 64'(rf_write_en), 64'(exp_wr));
    if (rf_write_en === 1'b1) begin
      if (sb.size() == 0) begin
        chk({tag, "_sb_underflow"}, 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        chk({tag, "_addr"}, 64'(rf_write_addr), 64'(e.addr));
        chk({tag, "_data"}, 64'(rf_write_data), 64'(e.data));
        chk({tag, "_gid"},  64'(grant_id),      64'(e.gid));
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wen"},    64'(rf_write_en),   64'd0);
    chk({tag, "_waddr"},  64'(rf_write_addr), 64'd0);
    chk({tag, "_wdata"},  64'(rf_write_data), 64'd0);
    chk({tag, "_gid"},    64'(grant_id),      64'd0);
    chk({tag, "_locked"}, 64'(locked),        64'd0);
    chk({tag, "_ready"},  64'(req_ready),     64'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req_valid = '0;
    req_lock  = '0;
    for (int i = 0; i < N; i++) begin
      a[i] = '0;
      d[i] = '0;
    end

    // Reset: ready must stay low even with all requesters valid.
    req_valid = 3'b111;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;

    // 1: all valid, no lock -> 0,1,2,0 back to back.
    a[0] = 5'd1; d[0] = 16'hA000;
    a[1] = 5'd2; d[1] = 16'hA001;
    a[2] = 5'd3; d[2] = 16'hA002;
    step(3'b001, 1'b0, "t1_g0");
    d[0] = 16'hA010;
    step(3'b010, 1'b0, "t1_g1");
    step(3'b100, 1'b0, "t1_g2");
    step(3'b001, 1'b0, "t1_g0b");
    req_valid = 3'b000;
    step(3'b000, 1'b0, "t1_drain");

    // 2: single requester 1.
    a[1] = 5'd7; d[1] = 16'hBEEF;
    req_valid = 3'b010;
    step(3'b010, 1'b0, "t2_r1");
    req_valid = 3'b000;
    step(3'b000, 1'b0, "t2_drain");

    // 3: req0 burst capped at 4 beats while req2 waits.
    a[0] = 5'd10; d[0] = 16'h3000;
    req_valid = 3'b001; req_lock = 3'b001;
    step(3'b001, 1'b0, "t3_b1");
    a[2] = 5'd12; d[2] = 16'h5000;
    req_valid = 3'b101;
    d[0] = 16'h3001;
    step(3'b001, 1'b1, "t3_b2");
    d[0] = 16'h3002;
    step(3'b001, 1'b1, "t3_b3");
    d[0] = 16'h3003;
    step(3'b001, 1'b1, "t3_b4");
    step(3'b100, 1'b0, "t3_r2");
    d[2] = 16'h5001; d[0] = 16'h3004;
    step(3'b001, 1'b0, "t3_b5");
    req_lock = 3'b000; d[0] = 16'h3005;
    step(3'b001, 1'b1, "t3_b6");
    req_valid = 3'b100;
    step(3'b100, 1'b0, "t3_r2b");
    req_valid = 3'b000;
    step(3'b000, 1'b0, "t3_drain");

    // 4: owner goes idle for 3 cycles; others stall, beat count frozen.
    a[0] = 5'd20; d[0] = 16'h4000;
    a[1] = 5'd21; d[1] = 16'h4100;
    a[2] = 5'd22; d[2] = 16'h4200;
    req_valid = 3'b001; req_lock = 3'b001;
    step(3'b001, 1'b0, "t4_b1");
    req_valid = 3'b110;
    for (int k = 0; k < 3; k++) step(3'b000, 1'b1, $sformatf("t4_stall%0d", k));
    req_valid = 3'b111;
    d[0] = 16'h4001;
    step(3'b001, 1'b1, "t4_b2");
    d[0] = 16'h4002;
    step(3'b001, 1'b1, "t4_b3");
    d[0] = 16'h4003;
    step(3'b001, 1'b1, "t4_b4");
    req_valid = 3'b110; req_lock = 3'b000;
    step(3'b010, 1'b0, "t4_r1");
    req_valid = 3'b100;
    step(3'b100, 1'b0, "t4_r2");
    req_valid = 3'b000;
    step(3'b000, 1'b0, "t4_drain");

    // 5: reset in the middle of a locked burst.
    a[0] = 5'd30; d[0] = 16'h6000;
    req_valid = 3'b001; req_lock = 3'b001;
    step(3'b001, 1'b0, "t5_b1");
    d[0] = 16'h6001;
    step(3'b001, 1'b1, "t5_b2");
    req_valid = 3'b011;
    rst_n = 1'b0;
    step(3'b000, 1'b1, "t5_rst");
    #1;
    chk_reset_vals("t5_post");
    rst_n = 1'b1;
    req_lock = 3'b000;
    d[0] = 16'h6002; a[1] = 5'd31; d[1] = 16'h6100;
    step(3'b001, 1'b0, "t5_first");
    req_valid = 3'b000;
    step(3'b000, 1'b0, "t5_drain");

    // 6: write to register 0.
    a[1] = 5'd0; d[1] = 16'h1234;
    req_valid = 3'b010;
    step(3'b010, 1'b0, "t6_r0");
    req_valid = 3'b000;
    step(3'b000, 1'b0, "t6_drain");

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
